// File: rtl/audio_pwm_stream.sv
// Mono PWM audio output stage: a small sample FIFO feeds one duty value per
// 2^WIDTH-clock frame; the last duty is held when the FIFO runs dry.
`timescale 1ns/1ps
module audio_pwm_stream #(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_IN  = 1'b1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sample_tick,
    output logic             underrun,
    output logic             AUD_PWM,
    output logic             AUD_SD
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [WIDTH-1:0] CNT_LAST = '1;
    localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             sd_q, sd_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_word;

    // Extra pointer bit separates the full and empty cases when indices match.
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready    = reset_n && enable && !fifo_full;
    assign sample_tick = enable && (cnt_q == CNT_LAST);
    assign underrun    = sample_tick && fifo_empty;
    assign push        = in_valid && in_ready;
    assign pop         = sample_tick && !fifo_empty;

    generate
        if (SIGNED_IN) begin : g_signed
            assign push_word = {~in_data[WIDTH-1], in_data[WIDTH-2:0]};
        end else begin : g_unsigned
            assign push_word = in_data;
        end
    endgenerate

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        duty_d   = duty_q;
        pwm_d    = enable && (cnt_q < duty_q);
        sd_d     = enable;
        if (!enable) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            duty_d   = MIDSCALE;
        end else begin
            cnt_d = cnt_q + 1'b1;
            // Duty updates on the boundary edge so it governs the whole next frame.
            if (pop) begin
                duty_d   = mem_q[rd_ptr_q[AW-1:0]];
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_word;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            duty_q   <= MIDSCALE;
            pwm_q    <= 1'b0;
            sd_q     <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            sd_q     <= sd_d;
        end
    end

    assign AUD_PWM = pwm_q;
    assign AUD_SD  = sd_q;

endmodule

// File: tb/tb_audio_pwm_stream.sv
// Bench for audio_pwm_stream: queue-based frame model checked every cycle,
// directed frame-level scenarios with literal high counts, then random traffic.
`timescale 1ns/1ps
module tb_audio_pwm_stream;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = 256;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             sample_tick;
    logic             underrun;
    logic             AUD_PWM;
    logic             AUD_SD;

    audio_pwm_stream #(.WIDTH(WIDTH), .SIGNED_IN(1'b1), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sample_tick (sample_tick),
        .underrun    (underrun),
        .AUD_PWM     (AUD_PWM),
        .AUD_SD      (AUD_SD)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: frame position, current duty, and a queue of stored words.
    int m_cnt  = 0;
    int m_duty = FRAME / 2;
    int m_fifo[$];
    int m_pwm  = 0;
    int m_sd   = 0;

    function automatic int to_offset(input int v);
        int s;
        s = (v >= FRAME / 2) ? v - FRAME : v;
        return s + FRAME / 2;
    endfunction

    // Inputs change only at posedge+1, so at the negedge they are what the next edge sees.
    always @(negedge clk) begin : model_check
        int e_ready;
        int e_tick;
        int e_under;
        if (!reset_n) begin
            m_fifo.delete();
            m_cnt  = 0;
            m_duty = FRAME / 2;
            m_pwm  = 0;
            m_sd   = 0;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_tick", sample_tick, 0);
            chk("rst_underrun", underrun, 0);
            chk("rst_pwm", AUD_PWM, 0);
            chk("rst_sd", AUD_SD, 0);
        end else begin
            e_ready = (enable && m_fifo.size() < DEPTH) ? 1 : 0;
            e_tick  = (enable && m_cnt == FRAME - 1) ? 1 : 0;
            e_under = (e_tick == 1 && m_fifo.size() == 0) ? 1 : 0;
            chk("in_ready", in_ready, e_ready);
            chk("sample_tick", sample_tick, e_tick);
            chk("underrun", underrun, e_under);
            chk("aud_pwm", AUD_PWM, m_pwm);
            chk("aud_sd", AUD_SD, m_sd);
            m_pwm = (enable && m_cnt < m_duty) ? 1 : 0;
            m_sd  = enable ? 1 : 0;
            if (!enable) begin
                m_fifo.delete();
                m_cnt  = 0;
                m_duty = FRAME / 2;
            end else begin
                if (e_tick == 1 && m_fifo.size() > 0) m_duty = m_fifo.pop_front();
                if (in_valid && e_ready == 1) m_fifo.push_back(to_offset(int'(in_data)));
                m_cnt = (m_cnt + 1) % FRAME;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        int n;
        n = 0;
        step();
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 600);
        chk("push_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    // Returns at the negedge of the cnt=0 cycle following the next frame boundary.
    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 600);
        chk("sync_tick_found", sample_tick, 1);
        @(negedge clk);
    endtask

    // AUD_PWM lags cnt by one clock, so the window is cnt=1..255 then cnt=0.
    task automatic measure(input string tag, input int exp_highs, input int exp_under);
        int h;
        int u;
        int tpos;
        h = 0;
        u = 0;
        tpos = -1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            h += int'(AUD_PWM);
            u += int'(underrun);
            if (sample_tick) tpos = i;
        end
        chk({tag, "_highs"}, h, exp_highs);
        chk({tag, "_underruns"}, u, exp_under);
        chk({tag, "_tick_pos"}, tpos, FRAME - 2);
    endtask

    task automatic wait_model_cnt(input int target);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (m_cnt != target && n < 600);
        chk("model_cnt_reached", m_cnt, target);
    endtask

    initial begin : stim
        int acc;
        int n;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;

        // Signed words 0x00, 0x7F, 0x80 map to duties 128, 255, 0.
        push(8'h00);
        push(8'h7F);
        push(8'h80);
        sync_frame();
        measure("signed_00", 128, 0);
        measure("signed_7f", 255, 0);
        measure("signed_80", 0, 1);

        // One sample then starvation: duty 0xC0 held, underrun every frame.
        push(8'h40);
        sync_frame();
        measure("underrun_a", 192, 1);
        measure("underrun_b", 192, 1);

        // Push on an empty boundary: underrun now, sample used one frame later.
        n = 0;
        do begin
            step();
            n++;
        end while (m_cnt != FRAME - 1 && n < 600);
        in_valid = 1'b1;
        in_data  = 8'hE0;
        @(negedge clk);
        chk("same_cycle_underrun", underrun, 1);
        chk("same_cycle_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        measure("same_cycle_hold", 192, 0);
        measure("same_cycle_load", 96, 1);

        // Backpressure: four accepted, then one more only after a pop.
        step();
        enable = 1'b0;
        step();
        enable = 1'b1;
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_data = WIDTH'($urandom_range(0, FRAME - 1));
            @(negedge clk);
            acc += int'(in_ready);
            step();
        end
        chk("bp_accepted", acc, DEPTH);
        chk("bp_ready_low", in_ready, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 600);
        chk("bp_tick_ready", in_ready, 0);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acc += int'(in_ready);
        end
        chk("bp_after_tick", acc, 1);
        step();
        in_valid = 1'b0;

        // Enable drop with three entries queued; re-enable starts from a flushed FIFO.
        enable = 1'b0;
        step();
        enable = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_model_cnt(40);
        chk("pre_disable_pwm", AUD_PWM, 1);
        enable = 1'b0;
        step();
        chk("disable_pwm", AUD_PWM, 0);
        chk("disable_sd", AUD_SD, 0);
        chk("disable_ready", in_ready, 0);
        repeat (4) step();
        enable = 1'b1;
        @(negedge clk);
        measure("reenable", 128, 1);

        // Asynchronous reset mid-frame while AUD_PWM is high.
        wait_model_cnt(20);
        chk("pre_reset_pwm", AUD_PWM, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_pwm", AUD_PWM, 0);
        chk("async_rst_sd", AUD_SD, 0);
        chk("async_rst_ready", in_ready, 0);
        repeat (3) step();
        reset_n = 1'b1;
        @(negedge clk);
        measure("post_reset", 128, 1);

        // Random traffic: sparse pushes, occasional single-cycle enable drops.
        for (int i = 0; i < 8000; i++) begin
            step();
            in_valid = ($urandom_range(0, 299) == 0);
            in_data  = WIDTH'($urandom_range(0, FRAME - 1));
            enable   = ($urandom_range(0, 1999) != 0);
        end
        step();
        in_valid = 1'b0;
        enable   = 1'b1;
        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/audio_pwm_stream.md
Name: audio_pwm_stream

Overview:
- Downstream audio output stage. Takes a stream of sample words from the modulator or message-select mux and drives the board's mono PWM audio pin.
- A small FIFO decouples producer timing from the PWM frame. One sample is consumed per PWM frame, and the last sample is held on underrun.
- Also drives the audio amplifier shutdown pin.

Parameters:
- WIDTH, 8: sample width in bits. The PWM frame is 2^WIDTH clocks.
- SIGNED_IN, 1: 1 means input samples are two's complement and are converted to offset binary. 0 means input is already unsigned.
- FIFO_DEPTH, 4: number of sample entries buffered. Must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  output enable. Low mutes, flushes the FIFO and asserts amplifier shutdown.
- in_data  in  WIDTH  sample word
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  block accepts in_data this cycle
- sample_tick  out  1  one-cycle pulse on the last clock of each PWM frame (frame boundary)
- underrun  out  1  one-cycle pulse when a frame boundary finds the FIFO empty
- AUD_PWM  out  1  PWM audio output, registered
- AUD_SD  out  1  amplifier enable (1 = amp on), registered

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO emptied; frame counter cnt = 0; duty = 2^(WIDTH-1) (midscale silence).
  - AUD_PWM = 0, AUD_SD = 0, sample_tick = 0, underrun = 0.
  - in_ready = 0 while reset_n is low.
- Handshake:
  - in_ready = enable && !full, where full is evaluated from the occupancy at the start of the cycle.
  - A push occurs when in_valid && in_ready.
  - A pop in the same cycle does not make a full FIFO accept a push.
  - in_data must be held while in_valid is high and in_ready is low. The block does not depend on this.
- Conversion on push: if SIGNED_IN, the stored word is in_data with its MSB inverted (0x00→0x80, 0x7F→0xFF, 0x80→0x00 for WIDTH=8). Otherwise it is stored unchanged.
- Frame counter:
  - cnt is WIDTH bits and increments every clock while enable = 1, wrapping 2^WIDTH-1 → 0.
  - sample_tick = 1 exactly in cycles where cnt == 2^WIDTH-1 and enable = 1.
- Frame-boundary load (cycles with sample_tick):
  - FIFO not empty: pop the head into duty; the new duty is effective from the cycle where cnt = 0.
  - FIFO empty: duty unchanged and underrun pulses for that cycle.
  - A push in the same cycle as an empty-FIFO boundary is stored and is not used until the next frame.
- PWM:
  - AUD_PWM <= enable && (cnt < duty), registered, so it lags cnt by one clock.
  - duty = 0 gives constant low. duty = 2^WIDTH-1 gives 2^WIDTH-1 high clocks per frame.
  - Exactly duty high clocks per frame, contiguous, starting at cnt = 0.
- AUD_SD <= enable, registered.
- enable = 0 (synchronous):
  - Next edge: FIFO flushed, cnt = 0, duty = midscale, AUD_PWM = 0, AUD_SD = 0.
  - in_ready = 0 and sample_tick = 0 while enable is low.
  - No underrun pulses while disabled.
- enable 0→1: the first frame starts with cnt = 0 and midscale duty. The first pushed sample is loaded at the end of that frame.
- Occupancy tracking: FIFO_DEPTH+1 states via read/write pointers with an extra wrap bit. Pointers wrap modulo FIFO_DEPTH.
- Reset deasserted mid-frame: the block resumes from the reset state. No partial-frame artefacts beyond AUD_PWM = 0.
- Latency: a sample pushed into an empty FIFO at cycle t is loaded at the next boundary, and AUD_PWM reflects it from the cycle after the following cnt = 0.

Test Plan:
- Reset: assert reset_n=0 mid-frame with AUD_PWM high → AUD_PWM, AUD_SD, in_ready go 0 immediately. After release with enable=1, count AUD_PWM highs per 256-clock frame = 128.
- Signed conversion (WIDTH=8): push 0x00, 0x7F, 0x80 in successive frames → high counts 128, 255, 0 in the three frames after load. sample_tick spacing = 256 clocks.
- Backpressure: hold in_valid=1 with no boundary for 10 clocks → exactly 4 accepted, then in_ready=0. After the next sample_tick, in_ready returns to 1 for one push.
- Underrun: push one sample 0x40 (signed) and stop → frame with duty 0xC0 (192 highs). Next boundary pulses underrun once and duty stays 192. Underrun repeats every 256 clocks.
- Same-cycle push at an empty boundary: present a push on the sample_tick cycle → underrun=1 that cycle. The sample is loaded at the following boundary.
- Enable drop mid-frame with 3 entries queued: enable=0 → AUD_PWM=0, AUD_SD=0 next edge. On re-enable, the first frame gives 128 highs and underrun pulses at its end (FIFO was flushed).
